// File: rtl/inst_encoder_if.sv
// Handshake bundle for inst_encoder: decoded field tuples in, instruction words out.
interface inst_encoder_if #(
    parameter int ADDR_W    = 10,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           in_opcode;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [31:0]          in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_inst;
    logic [ADDR_W-1:0]    out_addr;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err, err_count
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err, err_count
    );
endinterface

// File: rtl/inst_encoder.sv
// RV64I instruction encoder: field tuples -> 32-bit words in a 2-stage valid/ready pipeline.
// Optional macro RV64W_EN enables the 32-bit W opcodes (0111011, 0011011).
module inst_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    inst_encoder_if.slave bus
);

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OP_IMM32 = 7'b0011011;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        f = FMT_BAD;
        case (op)
            7'b0110011:                                               f = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: f = FMT_I;
            7'b0100011:                                               f = FMT_S;
            7'b1100011:                                               f = FMT_B;
            7'b0110111, 7'b0010111:                                   f = FMT_U;
            7'b1101111:                                               f = FMT_J;
`ifdef RV64W_EN
            7'b0111011:                                               f = FMT_R;
            7'b0011011:                                               f = FMT_I;
`else
            7'b0111011, 7'b0011011:                                   f = FMT_BAD;
`endif
            default:                                                  f = FMT_BAD;
        endcase
        return f;
    endfunction

    function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
        return ((op == OP_IMM) || (op == OP_IMM32)) && ((f3 == 3'b001) || (f3 == 3'b101));
    endfunction

    function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic imm_err(input fmt_e f, input logic [6:0] op, input logic [2:0] f3,
                                     input logic [31:0] imm);
        logic signed [31:0] v;
        logic               e;
        v = $signed(imm);
        e = 1'b0;
        case (f)
            FMT_R:   e = 1'b0;
            FMT_I: begin
                if (is_shift(op, f3))
                    e = !in_range(v, 0, (op == OP_IMM32) ? 31 : 63);
                else
                    e = !in_range(v, -2048, 2047);
            end
            FMT_S:   e = !in_range(v, -2048, 2047);
            FMT_B:   e = imm[0] || !in_range(v, -4096, 4094);
            FMT_J:   e = imm[0] || !in_range(v, -1048576, 1048574);
            FMT_U:   e = |imm[11:0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] assemble(input fmt_e f, input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
        logic [31:0] w;
        w = NOP;
        case (f)
            FMT_R: w = {f7, rs2, rs1, f3, rd, op};
            FMT_I: begin
                if (is_shift(op, f3))
                    w = {f7[6:1], imm[5:0], rs1, f3, rd, op};
                else
                    w = {imm[11:0], rs1, f3, rd, op};
            end
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = NOP;
        endcase
        return w;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    logic                 vld_p1_q,  vld_p1_d;
    logic                 vld_p2_q,  vld_p2_d;
    logic [31:0]          inst_p2_q, inst_p2_d;
    logic                 err_p2_q,  err_p2_d;
    logic [ADDR_W-1:0]    addr_q,    addr_d;
    logic [ERR_CNT_W-1:0] cnt_q,     cnt_d;

    logic [6:0]  op_p1_q;
    logic [2:0]  f3_p1_q;
    logic [6:0]  f7_p1_q;
    logic [4:0]  rd_p1_q, rs1_p1_q, rs2_p1_q;
    logic [31:0] imm_p1_q;
    fmt_e        fmt_p1_q;
    logic        err_p1_q;

    fmt_e fmt_p0;
    logic err_p0;
    logic in_hs, out_hs, adv_p2;

    // Stage 0: classify and validate the incoming tuple
    assign fmt_p0 = fmt_of(bus.in_opcode);
    assign err_p0 = imm_err(fmt_p0, bus.in_opcode, bus.in_funct3, bus.in_imm);

    assign out_hs       = vld_p2_q && bus.out_ready;
    assign adv_p2       = vld_p1_q && (!vld_p2_q || bus.out_ready);
    assign bus.in_ready = !vld_p1_q || adv_p2;
    assign in_hs        = bus.in_valid && bus.in_ready;

    always_comb begin
        vld_p1_d  = vld_p1_q;
        vld_p2_d  = vld_p2_q;
        inst_p2_d = inst_p2_q;
        err_p2_d  = err_p2_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        if (in_hs)
            vld_p1_d = 1'b1;
        else if (adv_p2)
            vld_p1_d = 1'b0;
        if (adv_p2) begin
            vld_p2_d  = 1'b1;
            err_p2_d  = err_p1_q;
            inst_p2_d = err_p1_q ? NOP
                      : assemble(fmt_p1_q, op_p1_q, f3_p1_q, f7_p1_q, rd_p1_q, rs1_p1_q, rs2_p1_q, imm_p1_q);
        end else if (out_hs) begin
            vld_p2_d = 1'b0;
        end
        if (out_hs) begin
            addr_d = addr_q + ADDR_W'(1);
            if (err_p2_q)
                cnt_d = sat_inc(cnt_q);
        end
    end

    // Stage 1: registered fields, format and error flag
    always_ff @(posedge clk) begin
        if (in_hs) begin
            op_p1_q  <= bus.in_opcode;
            f3_p1_q  <= bus.in_funct3;
            f7_p1_q  <= bus.in_funct7;
            rd_p1_q  <= bus.in_rd;
            rs1_p1_q <= bus.in_rs1;
            rs2_p1_q <= bus.in_rs2;
            imm_p1_q <= bus.in_imm;
            fmt_p1_q <= fmt_p0;
            err_p1_q <= err_p0;
        end
    end

    // Stage 2: assembled word, address and error bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            inst_p2_q <= '0;
            err_p2_q  <= 1'b0;
            addr_q    <= BASE_ADDR;
            cnt_q     <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            inst_p2_q <= inst_p2_d;
            err_p2_q  <= err_p2_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_valid = vld_p2_q;
    assign bus.out_inst  = inst_p2_q;
    assign bus.out_err   = err_p2_q;
    assign bus.out_addr  = addr_q;
    assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder with a field-level reference model and scoreboard.
module tb_inst_encoder;
    localparam int                ADDR_W    = 10;
    localparam int                ERR_CNT_W = 8;
    localparam logic [ADDR_W-1:0] BASE      = '0;
    localparam int                CNT_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef RV64W_EN
    localparam bit W_EN = 1'b1;
`else
    localparam bit W_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_encoder_if #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

    inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: {err, inst} from the field rules, using plain arithmetic.
    function automatic logic [32:0] model_enc(input int op, input int f3, input int f7, input int rd,
                                              input int rs1, input int rs2, input logic [31:0] imm);
        byte    fmt;
        bit     bad, sh;
        int     s;
        longint u, w;
        s = $signed(imm);
        u = longint'(imm);
        case (op)
            'h33:                          fmt = "R";
            'h3B:                          fmt = W_EN ? "R" : "X";
            'h13, 'h03, 'h67, 'h73, 'h0F:  fmt = "I";
            'h1B:                          fmt = W_EN ? "I" : "X";
            'h23:                          fmt = "S";
            'h63:                          fmt = "B";
            'h37, 'h17:                    fmt = "U";
            'h6F:                          fmt = "J";
            default:                       fmt = "X";
        endcase
        sh  = (op == 'h13 || op == 'h1B) && (f3 == 1 || f3 == 5);
        w   = 0;
        bad = 0;
        case (fmt)
            "R": w = (longint'(f7) << 25) + (longint'(rs2) << 20);
            "I": begin
                if (sh) begin
                    bad = (s < 0) || (s > ((op == 'h13) ? 63 : 31));
                    w   = (longint'(f7 / 2) << 26) + ((u % 64) << 20);
                end else begin
                    bad = (s < -2048) || (s > 2047);
                    w   = (u % 4096) << 20;
                end
            end
            "S": begin
                bad = (s < -2048) || (s > 2047);
                w   = (((u / 32) % 128) << 25) + (longint'(rs2) << 20) + ((u % 32) << 7);
            end
            "B": begin
                bad = (s % 2 != 0) || (s < -4096) || (s > 4094);
                w   = (((u / 4096) % 2) << 31) + (((u / 32) % 64) << 25) + (longint'(rs2) << 20)
                    + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7);
            end
            "U": begin
                bad = (u % 4096) != 0;
                w   = u - (u % 4096);
            end
            "J": begin
                bad = (s % 2 != 0) || (s < -1048576) || (s > 1048574);
                w   = (((u / 1048576) % 2) << 31) + (((u / 2) % 1024) << 21)
                    + (((u / 2048) % 2) << 20) + (((u / 4096) % 256) << 12);
            end
            default: bad = 1;
        endcase
        if (fmt inside {"R", "I", "S", "B"}) w += (longint'(rs1) << 15) + (longint'(f3) << 12);
        if (fmt inside {"R", "I", "U", "J"}) w += longint'(rd) << 7;
        w += op;
        if (bad) return {1'b1, 32'h0000_0013};
        return {1'b0, w[31:0]};
    endfunction

    // Scoreboard
    logic [32:0]       expq[$];
    int                m_addr, m_cnt, in_hs_cnt, out_hs_cnt;
    bit                mon_en = 1'b0;
    bit                prev_stall;
    logic [31:0]       prev_inst;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_err;

    always @(negedge clk) begin
        if (mon_en) begin
            logic [32:0] e;
            check("err_count", bus.err_count, m_cnt);
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_inst", bus.out_inst, prev_inst);
                check("stall_addr", bus.out_addr, prev_addr);
                check("stall_err", bus.out_err, prev_err);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_inst  = bus.out_inst;
            prev_addr  = bus.out_addr;
            prev_err   = bus.out_err;
            if (bus.out_valid && bus.out_ready) begin
                out_hs_cnt++;
                check("word_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("out_inst", bus.out_inst, e[31:0]);
                    check("out_err", bus.out_err, e[32]);
                    check("out_addr", bus.out_addr, m_addr);
                    m_addr = (m_addr + 1) % (1 << ADDR_W);
                    if (e[32] && m_cnt < CNT_MAX) m_cnt++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                in_hs_cnt++;
                expq.push_back(model_enc(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_rd,
                                         bus.in_rs1, bus.in_rs2, bus.in_imm));
            end
        end
    end

    logic [6:0] op_tbl[13] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73,
                               7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    int imm_tbl[20] = '{0, 1, -1, 2, 3, 31, 32, 63, 64, -2048, -2049, 2047, 2048,
                        -4096, -4098, 4094, 4096, -1048576, 1048574, 1048576};

    task automatic rand_fields();
        bus.in_opcode = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : op_tbl[$urandom_range(0, 12)];
        bus.in_funct3 = 3'($urandom());
        bus.in_funct7 = 7'($urandom());
        bus.in_rd     = 5'($urandom());
        bus.in_rs1    = 5'($urandom());
        bus.in_rs2    = 5'($urandom());
        case ($urandom_range(0, 3))
            0:       bus.in_imm = imm_tbl[$urandom_range(0, 19)];
            1:       bus.in_imm = $urandom_range(0, 8191) - 4096;
            2:       bus.in_imm = $urandom();
            default: bus.in_imm = $urandom() & 32'hFFFF_F000;
        endcase
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
        bus.in_opcode = op;  bus.in_funct3 = f3; bus.in_funct7 = f7;
        bus.in_rd = rd;      bus.in_rs1 = rs1;   bus.in_rs2 = rs2;
        bus.in_imm = imm;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        int n = 0;
        set_fields(op, f3, f7, rd, rs1, rs2, imm);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drive_accept", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        mon_en       = 1'b0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #12;
        expq.delete();
        m_addr     = int'(BASE);
        m_cnt      = 0;
        in_hs_cnt  = 0;
        out_hs_cnt = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((expq.size() != 0 || bus.out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", expq.size(), 0);
        check("drain_counts", out_hs_cnt, in_hs_cnt);
    endtask

    initial begin
        bit hs;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_inst", bus.out_inst, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_out_addr", bus.out_addr, BASE);
        check("rst_err_count", bus.err_count, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // ADD x3,x1,x2 with 2-cycle latency
        bus.out_ready = 1'b1;
        drive(7'h33, 0, 0, 3, 1, 2, 0);
        @(negedge clk);
        check("add_lat1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("add_valid", bus.out_valid, 1);
        check("add_inst", bus.out_inst, 32'h002081B3);
        check("add_addr", bus.out_addr, 0);
        check("add_err", bus.out_err, 0);
        drain();

        // ADDI x1,x0,-1 then BEQ x1,x2,+8 back-to-back
        do_reset();
        bus.out_ready = 1'b1;
        drive(7'h13, 0, 0, 1, 0, 0, -1);
        drive(7'h63, 0, 0, 0, 1, 2, 8);
        @(negedge clk);
        check("addi_inst", bus.out_inst, 32'hFFF00093);
        check("addi_addr", bus.out_addr, 0);
        @(negedge clk);
        check("beq_valid", bus.out_valid, 1);
        check("beq_inst", bus.out_inst, 32'h00208463);
        check("beq_addr", bus.out_addr, 1);
        drain();

        // JAL with odd offset becomes an errored NOP
        do_reset();
        bus.out_ready = 1'b1;
        drive(7'h6F, 0, 0, 1, 0, 0, 3);
        @(negedge clk);
        @(negedge clk);
        check("jal_valid", bus.out_valid, 1);
        check("jal_inst", bus.out_inst, 32'h00000013);
        check("jal_err", bus.out_err, 1);
        @(negedge clk);
        check("jal_err_count", bus.err_count, 1);
        drive(7'h33, 0, 0, 3, 1, 2, 0);
        @(negedge clk);
        @(negedge clk);
        check("after_jal_valid", bus.out_valid, 1);
        check("after_jal_err", bus.out_err, 0);
        drain();

        // Backpressure: two tuples fill the pipe, the third is held off
        do_reset();
        bus.out_ready = 1'b0;
        drive(7'h13, 0, 0, 1, 0, 0, 5);
        drive(7'h13, 0, 0, 2, 0, 0, 6);
        set_fields(7'h13, 0, 0, 3, 0, 0, 7);
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("third_blocked", bus.in_ready, 0);
        end
        check("stalled_addr", bus.out_addr, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();
        check("bp_words", out_hs_cnt, 3);

        // Asynchronous reset while a word is held at address 5
        do_reset();
        bus.out_ready = 1'b1;
        drive(7'h6F, 0, 0, 1, 0, 0, 3);
        for (int i = 0; i < 4; i++) drive(7'h33, 0, 0, 5'(i), 1, 2, 0);
        drain();
        bus.out_ready = 1'b0;
        drive(7'h37, 0, 0, 4, 0, 0, 32'h12345000);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", bus.out_valid, 1);
        check("pre_rst_addr", bus.out_addr, 5);
        check("pre_rst_cnt", bus.err_count, 1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_addr", bus.out_addr, BASE);
        check("async_rst_cnt", bus.err_count, 0);
        check("async_rst_err", bus.out_err, 0);
        do_reset();

        // ADDIW x1,x1,1 depends on the W-op build option
        bus.out_ready = 1'b1;
        drive(7'h1B, 0, 0, 1, 1, 0, 1);
        @(negedge clk);
        @(negedge clk);
        check("addiw_inst", bus.out_inst, W_EN ? 32'h0010809B : 32'h00000013);
        check("addiw_err", bus.out_err, W_EN ? 0 : 1);
        drain();

        // Error counter saturation
        do_reset();
        bus.out_ready = 1'b1;
        set_fields(7'h7F, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
        end
        drain();
        check("sat_err_count", bus.err_count, CNT_MAX);
        check("sat_addr", bus.out_addr, 300 % (1 << ADDR_W));

        // Full-throughput burst through the address wrap
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            rand_fields();
            @(posedge clk); #1;
        end
        drain();
        check("burst_accepted", in_hs_cnt, 1100);
        check("wrap_addr", bus.out_addr, 1100 % (1 << ADDR_W));

        // Random valid/ready traffic
        do_reset();
        rand_fields();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (hs || !bus.in_valid) begin
                rand_fields();
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
